irq_sched: RTL and testbench
============================

IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 Parameter NUM_SRC, default 8: number of interrupt sources; fixed at 8 for this revision.
REQ-002 Parameter ID_W, default 3: width of irq_id; equals clog2(NUM_SRC).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port a_rst  input  1: asynchronous, active-low reset.
REQ-005 Port src_req  input  NUM_SRC: level interrupt lines from peripherals; a rising edge raises a request.
REQ-006 Port mask_we  input  1: write strobe for the mask register.
REQ-007 Port mask_wdata  input  NUM_SRC: new mask value; bit=1 masks the source.
REQ-008 Port ts_fetch  input  1: core is at a fetch boundary; acknowledge is accepted only while high.
REQ-009 Port core_ack  input  1: core accepts the presented interrupt.
REQ-010 Port core_eoi  input  1: core signals end of interrupt service.
REQ-011 Port irq  output  1: interrupt request to the core.
REQ-012 Port irq_id  output  ID_W: index of the presented or in-service source.
REQ-013 Port irq_active  output  1: an interrupt is in service.
REQ-014 Port pending_q  output  NUM_SRC: pending register.
REQ-015 Port mask_q  output  NUM_SRC: mask register.

Function
REQ-016 Each src_req bit SHALL be registered every cycle; edge = src_req & ~src_req_q.
REQ-017 pending bit i SHALL set on edge i and clear when an acknowledge of id i is accepted; if both occur in the same cycle, it SHALL remain set.
REQ-018 Eligible = pending_q & ~mask_q; the selected source SHALL be the lowest-index eligible bit (index 0 = highest priority).
REQ-019 FSM states: IDLE, REQ, SERVICE.
REQ-020 IDLE -> REQ when eligible is nonzero; irq_id SHALL be loaded with the selected index and frozen while in REQ and SERVICE.
REQ-021 REQ -> SERVICE when core_ack & ts_fetch; core_ack without ts_fetch SHALL be ignored.
REQ-022 REQ -> IDLE when the frozen source becomes masked and no accepted acknowledge occurs in that cycle; an accepted acknowledge wins over the mask.
REQ-023 SERVICE -> IDLE on core_eoi; core_eoi in IDLE or REQ SHALL be ignored.
REQ-024 No nesting: new edges during SERVICE only set pending bits.
REQ-025 irq SHALL be 1 exactly when state is REQ; irq_active SHALL be 1 exactly when state is SERVICE; both registered.
REQ-026 Latency: an edge sampled on clock k SHALL drive irq high after clock k+1.
REQ-027 mask_we SHALL update mask_q on the same clock; masking never clears pending bits.
REQ-028 After SERVICE -> IDLE, the next request SHALL take one cycle in IDLE.

Reset
REQ-029 On a_rst low: state=IDLE, pending_q=0, mask_q=all ones, src_req_q=0, irq=0, irq_id=0, irq_active=0.
REQ-030 A reset mid-service SHALL discard the in-service and pending state without emitting core-facing pulses.

Structure
REQ-031 NUM_SRC, ID_W and the FSM state encoding SHALL be in the shared package qisp_pkg.
REQ-032 Selection SHALL be a combinational sub-module irq_prio_enc (vector in; valid and index out).

Verification
REQ-033 Reset check: mask_q=0xFF, with src_req=0x01 rising -> irq stays 0; write mask 0x00 -> irq=1, irq_id=0 two cycles later.
REQ-034 Priority: mask 0x00; src_req bits 5 and 2 rise together -> irq_id=2; ack+fetch, eoi -> next irq_id=5.
REQ-035 Ack gating: core_ack with ts_fetch=0 -> stay REQ; ack with ts_fetch=1 -> irq=0, irq_active=1, pending[id] cleared.
REQ-036 Re-edge collision: src 3 toggles on the ack cycle -> pending_q[3]=1 after ack; irq_id=3 again after eoi.
REQ-037 Mask withdrawal: in REQ for id 4, write mask 0x10 -> IDLE, irq=0, pending_q[4] still 1; unmask -> irq reasserted with id 4.
REQ-038 Reset during SERVICE -> all outputs 0, pending_q=0, mask_q=0xFF.

Source files
------------

// File: rtl/qisp_pkg.sv
// qisp_pkg: shared sizing and FSM encoding for the interrupt scheduler
package qisp_pkg;
  localparam int NUM_SRC = 8;
  localparam int ID_W = $clog2(NUM_SRC);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
endpackage

// File: rtl/irq_sched_if.sv
// irq_sched_if: peripheral/core-facing signal bundle of the interrupt scheduler
interface irq_sched_if #(
  parameter int NUM_SRC = qisp_pkg::NUM_SRC,
  parameter int ID_W = qisp_pkg::ID_W
);
  logic [NUM_SRC-1:0] src_req;
  logic mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic ts_fetch;
  logic core_ack;
  logic core_eoi;
  logic irq;
  logic [ID_W-1:0] irq_id;
  logic irq_active;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] mask_q;
  modport master (
    output src_req, mask_we, mask_wdata, ts_fetch, core_ack, core_eoi,
    input irq, irq_id, irq_active, pending_q, mask_q
  );
  modport slave (
    input src_req, mask_we, mask_wdata, ts_fetch, core_ack, core_eoi,
    output irq, irq_id, irq_active, pending_q, mask_q
  );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder
module irq_prio_enc #(
  parameter int NUM_SRC = qisp_pkg::NUM_SRC,
  parameter int ID_W = qisp_pkg::ID_W
) (
  input logic [NUM_SRC-1:0] vec,
  output logic valid,
  output logic [ID_W-1:0] idx
);
  always_comb begin
    valid = |vec;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (vec[i]) idx = ID_W'(i);
  end
endmodule

// File: rtl/irq_sched.sv
// irq_sched: edge-triggered maskable interrupt scheduler with REQ/SERVICE handshake
module irq_sched #(
  parameter int NUM_SRC = qisp_pkg::NUM_SRC,
  parameter int ID_W = qisp_pkg::ID_W
) (
  input logic clk,
  input logic a_rst,
  irq_sched_if.slave bus
);
  import qisp_pkg::*;
  logic [1:0] state, state_d;
  logic [NUM_SRC-1:0] src_q, edges, clr, eligible;
  logic sel_valid, accept, withdraw, load;
  logic [ID_W-1:0] sel_id;
  assign edges = bus.src_req & ~src_q;
  assign eligible = bus.pending_q & ~bus.mask_q;
  assign load = state == S_IDLE && sel_valid;
  assign accept = state == S_REQ && bus.core_ack && bus.ts_fetch;
  // an accepted acknowledge takes precedence over a late mask of the presented source
  assign withdraw = state == S_REQ && bus.mask_q[bus.irq_id] && !accept;
  assign clr = accept ? NUM_SRC'(1) << bus.irq_id : '0;
  assign state_d = load ? S_REQ :
                   accept ? S_SERVICE :
                   withdraw ? S_IDLE :
                   (state == S_SERVICE && bus.core_eoi) ? S_IDLE : state;
  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
    .vec(eligible),
    .valid(sel_valid),
    .idx(sel_id)
  );
  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) begin
      state <= S_IDLE;
      src_q <= '0;
      bus.pending_q <= '0;
      bus.mask_q <= '1;
      bus.irq <= 1'b0;
      bus.irq_id <= '0;
      bus.irq_active <= 1'b0;
    end else begin
      state <= state_d;
      src_q <= bus.src_req;
      bus.pending_q <= (bus.pending_q & ~clr) | edges;
      if (bus.mask_we) bus.mask_q <= bus.mask_wdata;
      if (load) bus.irq_id <= sel_id;
      bus.irq <= state_d == S_REQ;
      bus.irq_active <= state_d == S_SERVICE;
    end
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: table-driven scoreboard bench for irq_sched plus reset/latency sequences
module tb_irq_sched;
  typedef struct {
    logic [7:0] src;
    logic we;
    logic [7:0] wd;
    logic f;
    logic a;
    logic e;
    logic irq;
    logic act;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] mask;
  } vec_t;
  logic clk = 1'b0;
  logic a_rst = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];
  irq_sched_if bus ();
  irq_sched dut (.clk(clk), .a_rst(a_rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(logic [7:0] src, logic we, logic [7:0] wd, logic f, logic a, logic e,
                             logic irq, logic act, logic [2:0] id, logic [7:0] pend, logic [7:0] mask);
    v = '{src, we, wd, f, a, e, irq, act, id, pend, mask};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic chk_all(string tag, logic irq, logic act, logic [2:0] id, logic [7:0] pend, logic [7:0] mask);
    chk({tag, " irq"}, 32'(bus.irq), 32'(irq));
    chk({tag, " irq_active"}, 32'(bus.irq_active), 32'(act));
    chk({tag, " irq_id"}, 32'(bus.irq_id), 32'(id));
    chk({tag, " pending_q"}, 32'(bus.pending_q), 32'(pend));
    chk({tag, " mask_q"}, 32'(bus.mask_q), 32'(mask));
  endtask
  initial begin
    vec_t x;
    int cycles;
    bus.src_req = '0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;
    bus.ts_fetch = 1'b0;
    bus.core_ack = 1'b0;
    bus.core_eoi = 1'b0;
    // mask-gated first request, then unmask and serve
    tbl.push_back(v(8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 8'hFF));
    tbl.push_back(v(8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 8'hFF));
    tbl.push_back(v(8'h01, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00));
    tbl.push_back(v(8'h01, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h01, 8'h00));
    tbl.push_back(v(8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    // priority between 5 and 2, with ack gating on ts_fetch
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h24, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 0, 0, 1, 0, 2, 8'h24, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 1, 0, 1, 0, 2, 8'h24, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 1, 0, 0, 1, 0, 2, 8'h24, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 1, 1, 0, 0, 1, 2, 8'h20, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 0, 1, 0, 0, 2, 8'h20, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 0, 0, 1, 0, 5, 8'h20, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 1, 1, 0, 0, 1, 5, 8'h00, 8'h00));
    tbl.push_back(v(8'h24, 0, 8'h00, 0, 0, 1, 0, 0, 5, 8'h00, 8'h00));
    // src 3 re-edges on the accepted-ack cycle
    tbl.push_back(v(8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 5, 8'h08, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 0, 0, 0, 1, 0, 3, 8'h08, 8'h00));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 3, 8'h08, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 1, 1, 0, 0, 1, 3, 8'h08, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 0, 0, 1, 0, 0, 3, 8'h08, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 0, 0, 0, 1, 0, 3, 8'h08, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 1, 1, 0, 0, 1, 3, 8'h00, 8'h00));
    tbl.push_back(v(8'h08, 0, 8'h00, 0, 0, 1, 0, 0, 3, 8'h00, 8'h00));
    // mask withdrawal of id 4, unmask, then ack beats an already-applied mask
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h10, 8'h00));
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 0, 1, 0, 4, 8'h10, 8'h00));
    tbl.push_back(v(8'h18, 1, 8'h10, 0, 0, 0, 1, 0, 4, 8'h10, 8'h10));
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 0, 0, 0, 4, 8'h10, 8'h10));
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 0, 0, 0, 4, 8'h10, 8'h10));
    tbl.push_back(v(8'h18, 1, 8'h00, 0, 0, 0, 0, 0, 4, 8'h10, 8'h00));
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 0, 1, 0, 4, 8'h10, 8'h00));
    tbl.push_back(v(8'h18, 1, 8'h10, 0, 0, 0, 1, 0, 4, 8'h10, 8'h10));
    tbl.push_back(v(8'h18, 0, 8'h00, 1, 1, 0, 0, 1, 4, 8'h00, 8'h10));
    tbl.push_back(v(8'h18, 0, 8'h00, 0, 0, 1, 0, 0, 4, 8'h00, 8'h10));
    tbl.push_back(v(8'h18, 1, 8'h00, 0, 0, 0, 0, 0, 4, 8'h00, 8'h00));
    // enter SERVICE on id 0 with id 1 pending, ready for the reset test
    tbl.push_back(v(8'h19, 0, 8'h00, 0, 0, 0, 0, 0, 4, 8'h01, 8'h00));
    tbl.push_back(v(8'h19, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h01, 8'h00));
    tbl.push_back(v(8'h19, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    tbl.push_back(v(8'h1B, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h02, 8'h00));
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 8'h00, 8'hFF);
    a_rst = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.src_req = tbl[i].src;
      bus.mask_we = tbl[i].we;
      bus.mask_wdata = tbl[i].wd;
      bus.ts_fetch = tbl[i].f;
      bus.core_ack = tbl[i].a;
      bus.core_eoi = tbl[i].e;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk_all($sformatf("row%0d", i), x.irq, x.act, x.id, x.pend, x.mask);
    end
    @(negedge clk);
    bus.mask_we = 1'b0;
    bus.ts_fetch = 1'b0;
    bus.core_ack = 1'b0;
    bus.core_eoi = 1'b0;
    #2 a_rst = 1'b0;
    #1 chk_all("rst_in_service", 0, 0, 0, 8'h00, 8'hFF);
    bus.src_req = '0;
    @(negedge clk);
    a_rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 chk_all("post_reset_quiet", 0, 0, 0, 8'h00, 8'hFF);
    end
    // edge-to-irq latency on source 6
    @(negedge clk);
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'h00;
    @(negedge clk);
    bus.mask_we = 1'b0;
    bus.src_req = 8'h40;
    cycles = 0;
    while (cycles < 10) begin
      @(posedge clk);
      #1 cycles++;
      if (bus.irq) break;
    end
    chk("latency_cycles", 32'(cycles), 32'd2);
    chk("latency_id", 32'(bus.irq_id), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
